chip_rst_sequencer: RTL

Parametrised chip-level bring-up and reset sequencer for FPGA board tops. It merges N asynchronous readiness sources into one "ready" condition, e.g. clock generator lock, STARTUPE3 end-of-startup and DDR4 calibration complete. It debounces that condition, then releases M active-low domain resets one at a time with a programmable gap. It sits beside the clock generator and drives the resets of the debug transport, the SoC and the memory-side logic, replacing ad-hoc reset AND-ing in the top.

---
 rtl/chip_rst_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/chip_rst_sequencer.sv
// Chip bring-up sequencer: synchronises and debounces readiness, then releases domain resets in order.
// Optional readiness timeout / FAULT state is compiled in with `define RST_SEQ_TIMEOUT_EN.
module chip_rst_sequencer #(
    parameter int unsigned          NumReady       = 3,
    parameter logic [NumReady-1:0]  ReadyMask      = {NumReady{1'b1}},
    parameter int unsigned          NumDomains     = 4,
    parameter int unsigned          DebounceCycles = 16,
    parameter int unsigned          StageGapCycles = 8,
    parameter int unsigned          TimeoutCycles  = 1048576
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReady-1:0]   ready_i,
    input  logic                  sw_rst_req_i,
    output logic [NumDomains-1:0] rst_domain_no,
    output logic                  all_released_o,
    output logic [2:0]            state_o,
    output logic                  fault_o
);

    localparam int unsigned MaxDg  = (DebounceCycles > StageGapCycles) ? DebounceCycles : StageGapCycles;
    localparam int unsigned CntMax = (MaxDg > TimeoutCycles) ? MaxDg : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_DEBOUNCE   = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAULT      = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [NumReady-1:0]   sync1_q, sync1_d;
    logic [NumReady-1:0]   sync2_q, sync2_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NumDomains-1:0] rst_dom_q, rst_dom_d;
    logic                  all_rel_q, all_rel_d;
    logic                  fault_q, fault_d;
    logic                  ready_all;
    logic                  lose;

    // Masked-out bits are forced true so they can never hold the chip in reset.
    assign ready_all = &(sync2_q | ~ReadyMask);
    assign lose      = ~ready_all | sw_rst_req_i;

`ifdef RST_SEQ_TIMEOUT_EN
    logic [CntW-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        sync1_d   = ready_i;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_dom_d = rst_dom_q;
        all_rel_d = all_rel_q;
        fault_d   = fault_q;

        case (state_q)
            ST_RESET: begin
                state_d   = ST_WAIT_READY;
                cnt_d     = '0;
                idx_d     = '0;
                rst_dom_d = '0;
                all_rel_d = 1'b0;
            end
            ST_WAIT_READY: begin
                cnt_d     = '0;
                idx_d     = '0;
                rst_dom_d = '0;
                all_rel_d = 1'b0;
                if (ready_all) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (lose) begin
                    state_d = ST_WAIT_READY;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
                    rst_dom_d[0] = 1'b1;
                    cnt_d        = '0;
                    idx_d        = IdxW'(1);
                    if (NumDomains == 1) begin
                        state_d   = ST_RUN;
                        all_rel_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (lose) begin
                    state_d   = ST_WAIT_READY;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_dom_d = '0;
                    all_rel_d = 1'b0;
                end else if (cnt_q == CntW'(StageGapCycles - 1)) begin
                    rst_dom_d[idx_q] = 1'b1;
                    cnt_d            = '0;
                    if (idx_q == IdxW'(NumDomains - 1)) begin
                        state_d   = ST_RUN;
                        all_rel_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // All domains drop together; there is no partial re-assertion.
                if (lose) begin
                    state_d   = ST_WAIT_READY;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_dom_d = '0;
                    all_rel_d = 1'b0;
                end
            end
`ifdef RST_SEQ_TIMEOUT_EN
            ST_FAULT: begin
                rst_dom_d = '0;
                all_rel_d = 1'b0;
                fault_d   = 1'b1;
                if (sw_rst_req_i) begin
                    state_d = ST_WAIT_READY;
                    fault_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d   = ST_WAIT_READY;
                cnt_d     = '0;
                idx_d     = '0;
                rst_dom_d = '0;
                all_rel_d = 1'b0;
                fault_d   = 1'b0;
            end
        endcase

`ifdef RST_SEQ_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_q == ST_WAIT_READY || state_q == ST_DEBOUNCE) begin
            // A software re-sequence request restarts the bring-up window and beats the timeout.
            if (sw_rst_req_i) begin
                tmo_d = '0;
            end else if (tmo_q == CntW'(TimeoutCycles - 1)) begin
                state_d   = ST_FAULT;
                fault_d   = 1'b1;
                rst_dom_d = '0;
                all_rel_d = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
            end else if (state_d == ST_RELEASE || state_d == ST_RUN) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else if (state_q != ST_FAULT || sw_rst_req_i) begin
            tmo_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RESET;
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_dom_q <= '0;
            all_rel_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_dom_q <= rst_dom_d;
            all_rel_q <= all_rel_d;
            fault_q   <= fault_d;
        end
    end

    assign rst_domain_no  = rst_dom_q;
    assign all_released_o = all_rel_q;
    assign state_o        = state_q;
    assign fault_o        = fault_q;

endmodule
